// File: rtl/int_mv_ctrl.sv
// int_mv_ctrl: sequences y = M*x through one shared MAC, one row at a time.
// Each row clears the MAC, streams VEC_LEN operand pairs, then waits for the dot product.
module int_mv_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int VEC_LEN  = 16,
    parameter int NUM_ROWS = 16,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [ADDR_W-1:0]           m_addr,
    input  logic [BITWIDTH-1:0]         m_rdata,
    output logic [$clog2(VEC_LEN)-1:0]  v_addr,
    input  logic [BITWIDTH-1:0]         v_rdata,
    output logic                        mac_aresetn,
    output logic                        mac_valid,
    output logic [BITWIDTH-1:0]         mac_ain,
    output logic [BITWIDTH-1:0]         mac_bin,
    input  logic [BITWIDTH-1:0]         mac_dout,
    input  logic                        mac_dvalid,
    output logic                        res_we,
    output logic [$clog2(NUM_ROWS)-1:0] res_addr,
    output logic [BITWIDTH-1:0]         res_data
);

    localparam int KW = $clog2(VEC_LEN);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [KW-1:0] KLAST = KW'(VEC_LEN - 1);
    localparam logic [RW-1:0] RLAST = RW'(NUM_ROWS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

    state_t            state;
    state_t            nstate;
    logic [RW-1:0]     row;
    logic [KW-1:0]     k;
    logic [ADDR_W-1:0] maddr;
    logic [TW-1:0]     tcnt;
    logic              accept;
    logic              tmo;

    assign m_addr  = maddr;
    assign v_addr  = k;
    // read data returns one cycle after issue, so gate it with the delayed strobe
    assign mac_ain = mac_valid ? m_rdata : '0;
    assign mac_bin = mac_valid ? v_rdata : '0;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate      = state;
        busy        = (state != IDLE);
        done        = (state == DONE);
        mac_aresetn = aresetn & (state != CLR);
        accept      = (state == DRAIN) & mac_dvalid & ~mac_valid;
        tmo         = (state == DRAIN) & ~accept & (tcnt == TLAST);
        unique case (state)
            IDLE: begin
                if (start) nstate = CLR;
            end
            CLR: begin
                nstate = FEED;
            end
            FEED: begin
                if (k == KLAST) nstate = DRAIN;
            end
            DRAIN: begin
                if (accept) begin
                    nstate = (row == RLAST) ? DONE : CLR;
                end else if (tmo) begin
                    nstate = DONE;
                end
            end
            DONE: begin
                nstate = IDLE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            row       <= '0;
            k         <= '0;
            maddr     <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            mac_valid <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            mac_valid <= (state == FEED);
            res_we    <= accept;
            if (accept) begin
                res_data <= mac_dout;
                res_addr <= row;
            end
            unique case (state)
                IDLE: begin
                    row   <= '0;
                    k     <= '0;
                    maddr <= '0;
                    if (start) err <= 1'b0;
                end
                CLR: begin
                    k <= '0;
                end
                FEED: begin
                    // running address avoids a row*VEC_LEN multiply
                    maddr <= maddr + ADDR_W'(1);
                    k     <= (k == KLAST) ? '0 : k + KW'(1);
                    tcnt  <= '0;
                end
                DRAIN: begin
                    if (accept) begin
                        if (row != RLAST) row <= row + RW'(1);
                    end else if (tmo) begin
                        err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_mv_ctrl.sv
// Bench for int_mv_ctrl: buffer and MAC behavioural models plus a
// dot-product reference, driven by directed and random matrix runs.
module tb_int_mv_ctrl;

    localparam int BW  = 32;
    localparam int VL  = 4;
    localparam int NR  = 2;
    localparam int AW  = 8;
    localparam int TO  = 16;
    localparam int PED = 4;

    logic          clk;
    logic          aresetn;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_rdata;
    logic [1:0]    v_addr;
    logic [BW-1:0] v_rdata;
    logic          mac_aresetn;
    logic          mac_valid;
    logic [BW-1:0] mac_ain;
    logic [BW-1:0] mac_bin;
    logic [BW-1:0] mac_dout;
    logic          mac_dvalid;
    logic          res_we;
    logic [0:0]    res_addr;
    logic [BW-1:0] res_data;

    int_mv_ctrl #(
        .BITWIDTH(BW), .VEC_LEN(VL), .NUM_ROWS(NR), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .busy(busy),
        .done(done), .err(err), .m_addr(m_addr), .m_rdata(m_rdata),
        .v_addr(v_addr), .v_rdata(v_rdata), .mac_aresetn(mac_aresetn),
        .mac_valid(mac_valid), .mac_ain(mac_ain), .mac_bin(mac_bin),
        .mac_dout(mac_dout), .mac_dvalid(mac_dvalid), .res_we(res_we),
        .res_addr(res_addr), .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read matrix and vector buffers
    logic [BW-1:0] mmem [0:255];
    logic [BW-1:0] vmem [0:VL-1];
    always @(posedge clk) begin
        m_rdata <= mmem[m_addr];
        v_rdata <= vmem[v_addr];
    end

    // MAC model: accumulates products, reports the sum PED cycles after the last operand
    bit            mute = 1'b0;
    bit            glitch = 1'b0;
    logic [BW-1:0] acc;
    logic [BW-1:0] dout_q;
    logic          dv_q;
    logic          pend;
    int            since;
    always @(posedge clk) begin
        dv_q <= 1'b0;
        if (!mac_aresetn) begin
            acc    <= '0;
            pend   <= 1'b0;
            since  <= 0;
            dout_q <= '0;
        end else if (mac_valid) begin
            acc   <= acc + mac_ain * mac_bin;
            pend  <= 1'b1;
            since <= 0;
        end else if (pend) begin
            if (since == PED - 1) begin
                pend <= 1'b0;
                if (!mute) begin
                    dv_q   <= 1'b1;
                    dout_q <= acc;
                end
            end else begin
                since <= since + 1;
            end
        end
    end
    assign mac_dvalid = dv_q | (glitch & mac_valid);
    assign mac_dout   = (glitch & mac_valid) ? 32'hDEADBEEF : dout_q;

    // monitor: result writes, done pulses, mac_valid runs, MAC-clear cycles per row
    int wa [$];
    logic [BW-1:0] wd [$];
    int runs [$];
    int lowq [$];
    int n_done = 0;
    int run = 0;
    int lows = 0;
    int last_v = 0;
    always @(negedge clk) begin
        if (!aresetn) begin
            run  <= 0;
            lows <= 0;
        end else begin
            if (res_we) begin
                wa.push_back(int'(res_addr));
                wd.push_back(res_data);
            end
            if (done) n_done <= n_done + 1;
            if (mac_valid) begin
                if (run == 0) lowq.push_back(lows);
                run    <= run + 1;
                lows   <= 0;
                last_v <= cyc;
            end else begin
                if (run != 0) runs.push_back(run);
                run <= 0;
                if (!mac_aresetn) lows <= lows + 1;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic [BW-1:0] mat [0:NR-1][0:VL-1];
    logic [BW-1:0] xv [0:VL-1];

    task automatic program_mem();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < VL; c++)
                mmem[r * VL + c] = mat[r][c];
        for (int c = 0; c < VL; c++) vmem[c] = xv[c];
    endtask

    function automatic logic [BW-1:0] ref_row(input int r);
        logic [BW-1:0] s;
        s = '0;
        for (int c = 0; c < VL; c++) s = s + mat[r][c] * xv[c];
        return s;
    endfunction

    task automatic fill_rand();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < VL; c++)
                mat[r][c] = $urandom;
        for (int c = 0; c < VL; c++) xv[c] = $urandom;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " done seen"}, 64'(seen), 64'd1);
    endtask

    task automatic check_results(input string tag, input int wb, input int db, input int nrun);
        chk({tag, " writes"}, 64'(wd.size() - wb), 64'(NR * nrun));
        for (int i = 0; i < NR * nrun; i++) begin
            if (wb + i < wd.size()) begin
                chk($sformatf("%s addr%0d", tag, i), 64'(wa[wb + i]), 64'(i % NR));
                chk($sformatf("%s data%0d", tag, i), 64'(wd[wb + i]), 64'(ref_row(i % NR)));
            end
        end
        chk({tag, " done count"}, 64'(n_done - db), 64'(nrun));
        chk({tag, " err"}, 64'(err), 64'd0);
    endtask

    task automatic run_once(input string tag);
        int wb;
        int db;
        program_mem();
        wb = wd.size();
        db = n_done;
        pulse_start();
        wait_done(tag);
        repeat (3) @(negedge clk);
        check_results(tag, wb, db, 1);
    endtask

    initial begin
        int wb;
        int db;
        int rb;
        int lb;
        int dcyc;
        bit found;
        aresetn = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst mac_valid", 64'(mac_valid), 64'd0);
        chk("rst res_we", 64'(res_we), 64'd0);
        chk("rst m_addr", 64'(m_addr), 64'd0);
        chk("rst v_addr", 64'(v_addr), 64'd0);
        chk("rst res_addr", 64'(res_addr), 64'd0);
        chk("rst res_data", 64'(res_data), 64'd0);
        chk("rst mac_aresetn", 64'(mac_aresetn), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        // rows [1 2 3 4] and [-1 -2 -3 -4] against all-ones
        for (int c = 0; c < VL; c++) begin
            mat[0][c] = BW'(c + 1);
            mat[1][c] = -BW'(c + 1);
            xv[c]     = 32'd1;
        end
        rb = runs.size();
        lb = lowq.size();
        wb = wd.size();
        run_once("t1");
        if (wd.size() >= wb + 2) begin
            chk("t1 row0 value", 64'(wd[wb]), 64'd10);
            chk("t1 row1 value", 64'(wd[wb + 1]), 64'hFFFFFFF6);
        end
        chk("t2 valid runs", 64'(runs.size() - rb), 64'd2);
        for (int i = rb; i < runs.size(); i++)
            chk($sformatf("t2 run len %0d", i - rb), 64'(runs[i]), 64'(VL));
        chk("t2 clear count", 64'(lowq.size() - lb), 64'd2);
        for (int i = lb; i < lowq.size(); i++)
            chk($sformatf("t2 clear cycles %0d", i - lb), 64'(lowq[i]), 64'd1);

        // wrap-around: 4 * (0x7FFFFFFF * 2)
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < VL; c++)
                mat[r][c] = 32'h7FFFFFFF;
        for (int c = 0; c < VL; c++) xv[c] = 32'd2;
        wb = wd.size();
        run_once("t3");
        for (int i = wb; i < wd.size(); i++)
            chk($sformatf("t3 wrapped %0d", i - wb), 64'(wd[i]), 64'hFFFFFFF8);

        fill_rand();
        run_once("rand0");
        glitch = 1'b1;
        fill_rand();
        run_once("rand1 glitch");
        glitch = 1'b0;

        // MAC that never answers
        mute = 1'b1;
        program_mem();
        wb = wd.size();
        pulse_start();
        wait_done("t4");
        dcyc = cyc;
        chk("t4 err", 64'(err), 64'd1);
        chk("t4 timeout delay", 64'(dcyc - last_v), 64'(TO));
        @(negedge clk);
        chk("t4 busy after done", 64'(busy), 64'd0);
        chk("t4 no writes", 64'(wd.size() - wb), 64'd0);
        chk("t4 err sticky", 64'(err), 64'd1);
        mute = 1'b0;

        // start during FEED and in the done cycle is ignored
        fill_rand();
        program_mem();
        wb = wd.size();
        db = n_done;
        pulse_start();
        chk("t5 err cleared", 64'(err), 64'd0);
        chk("t5 busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5 first");
        start = 1'b1;
        @(negedge clk);
        chk("t5 start in done ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("t5 start in idle taken", 64'(busy), 64'd1);
        wait_done("t5 second");
        repeat (3) @(negedge clk);
        check_results("t5", wb, db, 2);

        // reset during row 1 FEED
        fill_rand();
        program_mem();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mac_aresetn) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6 row1 clear seen", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        chk("t6 busy", 64'(busy), 64'd0);
        chk("t6 done", 64'(done), 64'd0);
        chk("t6 mac_valid", 64'(mac_valid), 64'd0);
        chk("t6 res_we", 64'(res_we), 64'd0);
        chk("t6 m_addr", 64'(m_addr), 64'd0);
        chk("t6 v_addr", 64'(v_addr), 64'd0);
        chk("t6 res_data", 64'(res_data), 64'd0);
        chk("t6 mac_aresetn", 64'(mac_aresetn), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        run_once("t6 rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_mv_ctrl.md
Name: int_mv_ctrl

Overview:
Sequencer that computes a matrix-vector product y = M x on one shared int_mac processing element. It fetches matrix and vector elements from two synchronous-read buffers and streams them into the MAC one row at a time. Between rows it clears the MAC accumulator, waits for the MAC's dvalid, and writes each dot product to a result buffer. It sits between the top-level start/done control and the int_mac datapath.

Parameters:
BITWIDTH, 32, operand/result width (matches int_mac).
VEC_LEN, 16, elements per dot product (columns of M); must be >= 1.
NUM_ROWS, 16, rows of M, which is also the number of results; must be >= 1.
ADDR_W, 8, matrix address width; 2^ADDR_W must be >= NUM_ROWS*VEC_LEN.
TIMEOUT, 16, maximum number of DRAIN cycles to wait for mac_dvalid.

Ports:
clk  in  1  clock, all logic on the rising edge.
aresetn  in  1  synchronous, active-low reset.
start  in  1  one-cycle request to begin; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of a run.
err  out  1  sticky timeout flag; cleared on reset or on an accepted start.
m_addr  out  ADDR_W  matrix buffer read address, row-major (row*VEC_LEN+k).
m_rdata  in  BITWIDTH  matrix data, valid 1 cycle after m_addr.
v_addr  out  $clog2(VEC_LEN)  vector buffer read address.
v_rdata  in  BITWIDTH  vector data, valid 1 cycle after v_addr.
mac_aresetn  out  1  reset to the int_mac; equals aresetn AND NOT(state==CLR).
mac_valid  out  1  operand strobe to the int_mac.
mac_ain  out  BITWIDTH  m_rdata when mac_valid is high, else 0.
mac_bin  out  BITWIDTH  v_rdata when mac_valid is high, else 0.
mac_dout  in  BITWIDTH  accumulated sum from the int_mac.
mac_dvalid  in  1  result strobe from the int_mac.
res_we  out  1  result write enable, one-cycle pulse per row.
res_addr  out  $clog2(NUM_ROWS)  result row index.
res_data  out  BITWIDTH  captured mac_dout.

Behaviour:
- Reset (aresetn=0): state goes to IDLE. busy, done, err, mac_valid, res_we, m_addr, v_addr, res_addr and res_data all go to 0. mac_aresetn is held low.
- States: IDLE, CLR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 moves to CLR.
  - row=0, m_addr counter=0, err cleared.
- CLR:
  - Lasts exactly 1 cycle; mac_aresetn=0 clears the MAC accumulator.
  - No read is issued; moves to FEED with k=0.
- FEED:
  - Lasts exactly VEC_LEN cycles. Each cycle issues m_addr=base+k and v_addr=k, then k++.
  - m_addr is a running incrementing counter; no multiplier is used.
  - After the read with k=VEC_LEN-1 is issued, moves to DRAIN.
- mac_valid is the FEED read-issue flag registered by 1 cycle, so it aligns with the returned data. The result is exactly VEC_LEN consecutive mac_valid cycles per row, the last one falling in the first DRAIN cycle.
- DRAIN:
  - The timeout counter starts at 0 on entry.
  - On mac_dvalid=1 in a cycle where mac_valid=0: res_data<=mac_dout, res_addr<=row, res_we pulses next cycle. Then:
    - if row==NUM_ROWS-1, move to DONE;
    - otherwise row++ and move to CLR.
  - If the counter reaches TIMEOUT-1 with no dvalid: set err=1, skip the remaining rows, and move to DONE.
- DONE: done=1 for 1 cycle, then return to IDLE.
- mac_dvalid is ignored outside DRAIN and when it coincides with mac_valid.
- start while busy is ignored. start in the done cycle is ignored; it is accepted the cycle after, in IDLE.
- Per-row cycle count: 1 (CLR) + VEC_LEN (FEED) + DRAIN wait.
- Arithmetic: no arithmetic in this block. Wrap-around of the result is whatever the MAC produces.
- Reset mid-run: immediate return to IDLE. No done pulse, no res_we, and the MAC is reset through mac_aresetn.

Test Plan:
1. VEC_LEN=4, NUM_ROWS=2, M=[1 2 3 4; -1 -2 -3 -4], x=[1 1 1 1], real int_mac with PE_DELAY=4 -> res writes (0,10) then (1,-10), one done pulse, err=0.
2. Same run: check mac_valid is high for exactly 4 consecutive cycles per row, and mac_aresetn is low for exactly 1 cycle before each row's first mac_valid.
3. M all 0x7FFFFFFF, x all 2, VEC_LEN=4 -> res_data equals the 32-bit wrapped sum 0xFFFFFFF8, written to each row.
4. MAC model that never raises dvalid, TIMEOUT=16 -> err=1 and done pulse 16 cycles after DRAIN entry, no res_we, busy low the next cycle.
5. start pulsed during FEED and in the done cycle -> both ignored; start pulsed 1 cycle later in IDLE -> new run, err cleared.
6. aresetn=0 during row 1 FEED -> next cycle is IDLE with all outputs 0; a following start produces a correct full result set.
